// File: rtl/req_arbiter10_enc_if.sv
// Request/grant bus of the 10-way round-robin arbiter with encoded grant output.
interface req_arbiter10_enc_if;
  logic [9:0] i_req;
  logic       i_ready;
  logic [9:0] o_grant;
  logic [3:0] o_code;
  logic       o_valid;
  logic       o_timeout;

  modport master (
    output i_req, i_ready,
    input  o_grant, o_code, o_valid, o_timeout
  );

  modport slave (
    input  i_req, i_ready,
    output o_grant, o_code, o_valid, o_timeout
  );
endinterface

// File: rtl/req_arbiter10_enc.sv
// Round-robin arbiter over 10 request lines; holds a registered one-hot grant and
// its 1..10 code on a valid/ready handshake, with an optional ready timeout.
module req_arbiter10_enc #(
  parameter int unsigned TIMEOUT = 0,
  parameter int unsigned CNT_W   = 8
) (
  input  logic               i_clk,
  input  logic               i_rst,
  req_arbiter10_enc_if.slave bus
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [CNT_W-1:0] TO_LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [9:0]       grant_q, grant_d;
  logic [3:0]       code_q, code_d;
  logic [3:0]       ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;

  logic             pick_found;
  logic [3:0]       pick_idx;
  logic [4:0]       cand;
  logic [3:0]       next_ptr;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      code_q    <= '0;
      ptr_q     <= '0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      code_q    <= code_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  // Rotating search starting at ptr_q; first set request wins.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int unsigned i = 0; i < 10; i++) begin
      cand = 5'(ptr_q) + 5'(i);
      if (cand >= 5'd10) cand = cand - 5'd10;
      if (!pick_found && bus.i_req[cand[3:0]]) begin
        pick_found = 1'b1;
        pick_idx   = cand[3:0];
      end
    end
  end

  // code_q is g+1, which is exactly the next pointer except for the 9 -> 0 wrap.
  assign next_ptr = (code_q == 4'd10) ? '0 : code_q;

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    code_d    = code_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        grant_d = '0;
        code_d  = '0;
        cnt_d   = '0;
        if (pick_found) begin
          state_d = GRANT;
          grant_d = 10'd1 << pick_idx;
          code_d  = pick_idx + 4'd1;
        end
      end
      GRANT: begin
        if (bus.i_ready) begin
          state_d = IDLE;
          grant_d = '0;
          code_d  = '0;
          cnt_d   = '0;
          ptr_d   = next_ptr;
        end else if (TIMEOUT != 0 && cnt_q == TO_LAST) begin
          state_d   = IDLE;
          grant_d   = '0;
          code_d    = '0;
          cnt_d     = '0;
          ptr_d     = next_ptr;
          timeout_d = 1'b1;
        end else if (TIMEOUT != 0) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.o_grant   = grant_q;
    bus.o_code    = code_q;
    bus.o_valid   = (state_q == GRANT);
    bus.o_timeout = timeout_q;
  end

endmodule

// File: tb/tb_req_arbiter10_enc.sv
// Directed bench: vector table on a no-timeout arbiter, hand sequences on a TIMEOUT=4 one.
module tb_req_arbiter10_enc;

  logic clk;
  logic rst_a;
  logic rst_b;

  int total;
  int bad;

  req_arbiter10_enc_if bus_a ();
  req_arbiter10_enc_if bus_b ();

  req_arbiter10_enc #(.TIMEOUT(0), .CNT_W(8)) dut_a (
    .i_clk (clk),
    .i_rst (rst_a),
    .bus   (bus_a)
  );

  req_arbiter10_enc #(.TIMEOUT(4), .CNT_W(8)) dut_b (
    .i_clk (clk),
    .i_rst (rst_b),
    .bus   (bus_b)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [9:0] req;
    logic       ready;
    logic [3:0] code;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic r, input logic [9:0] q, input logic rd, input logic [3:0] c);
    vec_t v;
    v.rst   = r;
    v.req   = q;
    v.ready = rd;
    v.code  = c;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_b(input string name, input logic [3:0] code, input logic to);
    logic [9:0] g;
    g = (code == 4'd0) ? 10'd0 : (10'd1 << (code - 4'd1));
    chk({name, ".grant"},   32'(bus_b.o_grant),   32'(g));
    chk({name, ".code"},    32'(bus_b.o_code),    32'(code));
    chk({name, ".valid"},   32'(bus_b.o_valid),   32'(code != 4'd0));
    chk({name, ".timeout"}, 32'(bus_b.o_timeout), 32'(to));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] exp_g;
    string nm;
    clk = 1'b0;
    rst_a = 1'b1;
    rst_b = 1'b1;
    bus_a.i_req = '0;
    bus_a.i_ready = 1'b0;
    bus_b.i_req = '0;
    bus_b.i_ready = 1'b0;
    total = 0;
    bad = 0;

    // reset then idle
    add(1, 10'h000, 0, 0);
    repeat (5) add(0, 10'h000, 0, 0);
    // single requester 2, bubble between grants, then ptr=3 favours bit 3
    add(0, 10'h004, 1, 3); add(0, 10'h004, 1, 0);
    add(0, 10'h004, 1, 3); add(0, 10'h004, 1, 0);
    add(0, 10'h00C, 1, 4); add(0, 10'h00C, 1, 0);
    // all requesting: 1..10 then wrap
    add(1, 10'h3FF, 1, 0);
    for (int k = 0; k < 12; k++) begin
      add(0, 10'h3FF, 1, 4'((k % 10) + 1));
      add(0, 10'h3FF, 1, 0);
    end
    // requesters 0 and 9 alternate
    add(1, 10'h201, 1, 0);
    add(0, 10'h201, 1, 1);  add(0, 10'h201, 1, 0);
    add(0, 10'h201, 1, 10); add(0, 10'h201, 1, 0);
    add(0, 10'h201, 1, 1);  add(0, 10'h201, 1, 0);
    // grant held without ready (no timeout), request drop ignored, reset mid-grant
    add(0, 10'h080, 0, 8);
    repeat (11) add(0, 10'h000, 0, 8);
    add(1, 10'h081, 0, 0);
    add(0, 10'h081, 1, 1);
    add(0, 10'h081, 1, 0);
    add(0, 10'h081, 1, 8);

    foreach (vecs[i]) begin
      rst_a = vecs[i].rst;
      bus_a.i_req = vecs[i].req;
      bus_a.i_ready = vecs[i].ready;
      @(posedge clk);
      #1;
      exp_g = (vecs[i].code == 4'd0) ? 10'd0 : (10'd1 << (vecs[i].code - 4'd1));
      nm = $sformatf("vec%0d", i);
      chk({nm, ".grant"},   32'(bus_a.o_grant),   32'(exp_g));
      chk({nm, ".code"},    32'(bus_a.o_code),    32'(vecs[i].code));
      chk({nm, ".valid"},   32'(bus_a.o_valid),   32'(vecs[i].code != 4'd0));
      chk({nm, ".timeout"}, 32'(bus_a.o_timeout), 1'b0);
    end

    // TIMEOUT=4: four valid cycles, timeout pulse, re-grant
    rst_b = 1'b1;
    @(posedge clk);
    #1;
    chk_b("b_reset", 4'd0, 1'b0);
    rst_b = 1'b0;
    bus_b.i_req = 10'h020;
    bus_b.i_ready = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      @(posedge clk);
      #1;
      chk_b($sformatf("b_hold%0d", c), 4'd6, 1'b0);
    end
    @(posedge clk);
    #1;
    chk_b("b_timeout", 4'd0, 1'b1);
    @(posedge clk);
    #1;
    chk_b("b_regrant", 4'd6, 1'b0);

    // ready on the last allowed cycle: accept wins over timeout
    for (int c = 2; c <= 4; c++) begin
      @(posedge clk);
      #1;
      chk_b($sformatf("b_wait%0d", c), 4'd6, 1'b0);
    end
    bus_b.i_ready = 1'b1;
    bus_b.i_req = 10'h000;
    @(posedge clk);
    #1;
    chk_b("b_accept_late", 4'd0, 1'b0);
    @(posedge clk);
    #1;
    chk_b("b_idle", 4'd0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
